// File: rtl/instr_sequencer.sv
// Program store and issue engine feeding a CPU instruction port.
// Words are loaded while idle/halted, then issued one per CPI cycles from start_addr until HALT or stop.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH    = 20,
  parameter int                     PROG_ADDR_BITS = 5,
  parameter int                     CPI            = 4,
  parameter logic [3:0]             HALT_OP        = 4'hF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_en,
  input  logic [PROG_ADDR_BITS-1:0] load_addr,
  input  logic [INSTR_WIDTH-1:0]    load_data,
  input  logic                      start,
  input  logic [PROG_ADDR_BITS-1:0] start_addr,
  input  logic                      stop,
  output logic [INSTR_WIDTH-1:0]    instruction,
  output logic                      instr_valid,
  output logic [PROG_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      halted,
  output logic [15:0]               instr_count
);

  localparam int         DEPTH     = 1 << PROG_ADDR_BITS;
  localparam logic [3:0] HOLD_LAST = 4'(CPI - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  state_e                      state_q, state_d;
  logic [INSTR_WIDTH-1:0]      instruction_q, instruction_d;
  logic                        instr_valid_q, instr_valid_d;
  logic [PROG_ADDR_BITS-1:0]   pc_q, pc_d;
  logic [15:0]                 instr_count_q, instr_count_d;
  logic                        stop_q, stop_d;
  logic [3:0]                  hold_q, hold_d;
  logic [INSTR_WIDTH-1:0]      mem_q [DEPTH];

  logic                        mem_we;
  logic [PROG_ADDR_BITS-1:0]   fetch_addr;
  logic [INSTR_WIDTH-1:0]      fetch_word;
  logic                        fetch_halt;

  // Asynchronous read: a same-cycle write to fetch_addr is not visible until the next edge.
  always_comb begin
    fetch_addr = (state_q == S_RUN) ? pc_q + PROG_ADDR_BITS'(1) : start_addr;
    fetch_word = mem_q[fetch_addr];
    fetch_halt = (fetch_word[INSTR_WIDTH-1 -: 4] == HALT_OP);
  end

  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    instr_valid_d = 1'b0;
    pc_d          = pc_q;
    instr_count_d = instr_count_q;
    stop_d        = stop_q;
    hold_d        = hold_q;
    mem_we        = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        mem_we = load_en;
        if (start) begin
          hold_d        = '0;
          stop_d        = 1'b0;
          instr_count_d = '0;
          pc_d          = start_addr;
          if (fetch_halt) begin
            state_d       = S_HALTED;
            instruction_d = NOP_INSTR;
          end else begin
            state_d       = S_RUN;
            instruction_d = fetch_word;
            instr_valid_d = 1'b1;
            instr_count_d = 16'd1;
          end
        end
      end
      S_RUN: begin
        stop_d = stop_q | stop;
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          pc_d   = fetch_addr;
          // Only a stop latched before this edge counts; a stop sampled here waits for the next boundary.
          if (stop_q || fetch_halt) begin
            state_d       = S_HALTED;
            instruction_d = NOP_INSTR;
            stop_d        = 1'b0;
          end else begin
            instruction_d = fetch_word;
            instr_valid_d = 1'b1;
            stop_d        = stop;
            if (instr_count_q != 16'hFFFF) instr_count_d = instr_count_q + 16'd1;
          end
        end else begin
          hold_d = hold_q + 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instruction_q <= NOP_INSTR;
      instr_valid_q <= 1'b0;
      pc_q          <= '0;
      instr_count_q <= '0;
      stop_q        <= 1'b0;
      hold_q        <= '0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      instr_valid_q <= instr_valid_d;
      pc_q          <= pc_d;
      instr_count_q <= instr_count_d;
      stop_q        <= stop_d;
      hold_q        <= hold_d;
    end
  end

  // Program memory survives reset; reset only blocks a write in the same cycle.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[load_addr] <= load_data;
  end

  assign instruction = instruction_q;
  assign instr_valid = instr_valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == S_RUN);
  assign halted      = (state_q == S_HALTED);
  assign instr_count = instr_count_q;

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Program store and issue engine that drives the 20-bit `instruction` input of `simple_cpu`. Holds a loadable program memory, and on `start` runs it from a given address. Each word is presented for a fixed number of cycles per instruction, so the CPU's control unit sees a stable instruction for its full execute sequence. Issue stops on a HALT opcode or an external `stop`.

## Interface
- `INSTR_WIDTH`, 20: instruction word width; opcode is `[INSTR_WIDTH-1:INSTR_WIDTH-4]`.
- `PROG_ADDR_BITS`, 5: program memory address width (32 words).
- `CPI`, 4: clock cycles each instruction is held; legal range 1..16.
- `HALT_OP`, 4'hF: opcode value that terminates the program.
- `NOP_INSTR`, 20'h00000: value driven on `instruction` when not issuing.
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  reset is synchronous and active-high.
- `load_en`  in  1  program write strobe; honoured only in IDLE or HALTED.
- `load_addr`  in  PROG_ADDR_BITS  write address.
- `load_data`  in  INSTR_WIDTH  write data.
- `start`  in  1  begin execution; honoured only in IDLE or HALTED.
- `start_addr`  in  PROG_ADDR_BITS  first PC value.
- `stop`  in  1  request halt at the next instruction boundary; honoured only in RUN.
- `instruction`  out  INSTR_WIDTH  registered instruction to the CPU.
- `instr_valid`  out  1  high in the first cycle of each issued instruction only.
- `pc`  out  PROG_ADDR_BITS  address of the word currently on `instruction`.
- `busy`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.
- `instr_count`  out  16  instructions issued since last `start`; saturates at 16'hFFFF.

## Operation
- Program memory: 2^PROG_ADDR_BITS × INSTR_WIDTH, asynchronous read, synchronous write. `rst` does not clear it.
- The state machine has three states:
  - IDLE (after reset): `start` → RUN.
  - RUN: a HALT fetch or a pending stop at a boundary → HALTED.
  - HALTED: `start` → RUN.
- Boundary: the edge that starts execution, then every CPI cycles afterwards. An internal hold counter runs 0..CPI-1; the boundary occurs when it reaches CPI-1.
- At `start`:
  - PC ← `start_addr`.
  - `instr_count` ← 0.
  - Stop request cleared.
  - The first fetch happens at the same edge.
- At each RUN boundary, fetch `mem[next_pc]` and act on it:
  - Stop pending, or fetched opcode == HALT_OP → HALTED. `instruction` ← NOP_INSTR, `instr_valid` ← 0, `pc` ← address of the unissued word.
  - Otherwise → `instruction` ← word, `instr_valid` ← 1 for one cycle, `pc` ← address, `instr_count` += 1 (saturating).
- `next_pc` is `pc`+1 modulo 2^PROG_ADDR_BITS, so the PC wraps from 31 to 0. At the start edge it is `start_addr`.
- A HALT word is never issued to the CPU.
- `stop` is latched whenever it is asserted in RUN and acted on at the next boundary. `stop` in IDLE or HALTED is ignored.
- Ignored inputs:
  - `start` in RUN.
  - `load_en` in RUN.
- `load_en` and `start` in the same cycle in IDLE/HALTED: both take effect. The fetch reads the pre-write content if the addresses match.
- Stop pending and HALT fetched at the same boundary: HALTED, with identical outputs.

## Timing
- Reset values (edge after `rst`=1):
  - state IDLE.
  - `instruction`=NOP_INSTR.
  - `instr_valid`=0, `busy`=0, `halted`=0.
  - `pc`=0, `instr_count`=0.
  - Stop request cleared, hold counter 0.
- `rst` mid-RUN aborts at that edge; the CPU sees NOP_INSTR the next cycle. `rst` has priority over every other input.
- Latency: `start` sampled at edge t → first instruction visible after t, `instr_valid`=1 in cycle t..t+1.
- Instruction k (0-based) appears after edge t+k·CPI and is held stable for exactly CPI cycles.
- CPI=1: back-to-back issue; `instr_valid` stays high through RUN.
- HALT at word k: after edge t+k·CPI, `instruction`=NOP_INSTR, `busy`=0, `halted`=1.
- `stop` asserted at edge s in RUN: takes effect at the first boundary strictly after s. The instruction currently held always completes its CPI cycles.
- Write latency: a word written at edge w is fetchable from edge w+1.

## Test plan
- Reset, then load 0:0x1_2345, 1:0x2_0001, 2:0xF_0000, start_addr=0, CPI=4 → 0x12345 held for cycles 1-4 with `instr_valid` high in cycle 1 only; 0x20001 held for cycles 5-8; then `halted`=1, `instruction`=0, `instr_count`=2, `pc`=2.
- Wrap: a non-HALT program occupying 30,31,0 with HALT at 1, start_addr=30 → `pc` sequence 30,31,0, then halt with `pc`=1 and `instr_count`=3.
- `stop` pulsed in cycle 2 of the first instruction, on a program with no HALT → exactly 1 instruction issued, `halted` set at edge t+4, `instruction` returns to NOP.
- Ignored inputs in RUN: `load_en` to address 1 and `start` (start_addr=5) asserted mid-RUN → memory word 1 unchanged on readback, execution unperturbed.
- `rst` asserted in cycle 2 of the second instruction → next cycle shows all reset values. Restarting from 0 reissues the original program, proving memory is retained.
- CPI=1 parameterisation: 3-word program + HALT → `instr_valid` high for 3 consecutive cycles, then `halted`=1.
